clint_irq_arbiter: RTL and testbench
====================================

// Module: clint_irq_arbiter
// PURPOSE
//  Interrupt pending/arbitration controller between the CLINT source lines and the core.
//  - Captures rising edges on N_SRC peripheral lines (tim, uart_tx, uart_rx, fft, ...).
//  - Masks them with a bus-written enable register and picks one winner.
//  - Presents the winner to the core as a valid/id request held until irq_ack_i.
// PARAMETERS
//  N_SRC      4             number of interrupt sources (2..16)
//  ID_W       2             width of irq_id_o, clog2(N_SRC)
//  BASE_ADDR  32'h0000_2000 bus address of the ENABLE register; PEND_CLR is at BASE_ADDR+4
//  RR_EN      0             0 = fixed priority (lowest index wins); 1 = round-robin
// PORTS
//  clk          in   1        system clock, all logic on posedge
//  rst          in   1        synchronous reset, active-high
//  src_irq_i    in   N_SRC    raw peripheral interrupt levels
//  wr_en_i      in   1        bus write strobe, one cycle per write
//  addr_i       in   32       bus write address
//  data_i       in   32       bus write data
//  irq_valid_o  out  1        request to core
//  irq_id_o     out  ID_W     index of the requested source
//  irq_ack_i    in   1        core accepts the current request
//  pend_o       out  N_SRC    pending register, for readback
//  enable_o     out  N_SRC    enable register, for readback
// BEHAVIOUR
//  Reset
//  - On rst=1 at posedge: pend, enable, src_prev, rr_last=0, state=IDLE.
//  - Outputs after reset: irq_valid_o=0, irq_id_o=0, pend_o=0, enable_o=0.
//  - Reset mid-request drops the request next cycle, with no ack needed.
//  Edge detect
//  - src_prev <= src_irq_i each cycle.
//  - rise = src_irq_i & ~src_prev.
//  Pending register
//  - pend[i] sets on rise[i].
//  - pend[i] clears on an accepted ack for id i, or on a PEND_CLR write with data_i[i]=1 (write-1-to-clear).
//  - Set and clear on the same cycle: set wins, so the new edge is not lost.
//  Bus writes
//  - addr_i==BASE_ADDR: enable <= data_i[N_SRC-1:0].
//  - addr_i==BASE_ADDR+4: PEND_CLR.
//  - Any other address is ignored. Writes take effect the next cycle.
//  Eligibility
//  - elig = pend & enable, using current register values.
//  - Fixed mode: the lowest set index wins.
//  - RR_EN=1: search starts at rr_last+1, wraps modulo N_SRC; rr_last updates on each ack.
//  FSM (registered outputs)
//  - IDLE: valid=0. If |elig: latch the winner into irq_id_o, set irq_valid_o=1, go to REQ.
//  - REQ: valid=1, irq_id_o stable, never withdrawn. A later enable or pend change does not retract it.
//    On irq_ack_i=1: clear pend[id], valid<=0, go to GAP.
//  - GAP: one cycle with valid=0, so the core sees a deassert, then go to IDLE.
//  - irq_ack_i in IDLE or GAP is ignored.
//  - A PEND_CLR of the requested id while in REQ clears pend, but the request stays until acked.
//  Latency
//  - src rises, sampled at cycle t -> pend_o set at t+1 -> irq_valid_o=1 at t+2.
//  - Ack at cycle a -> valid=0 at a+1 (GAP) -> next request is at the earliest a+3.
//  Width rule
//  - irq_id_o is zero-extended from the winner index.
//  - Indices >= N_SRC are never produced.
// TESTING
//  1. Reset, enable=4'hF, pulse src[2] -> pend_o=4'h4 at t+1; valid=1, id=2 at t+2.
//     Ack -> pend_o=0, valid low for exactly 1 cycle.
//  2. Fixed priority, enable=4'hF, src[3] and src[1] rise together -> id=1 first.
//     After ack and GAP -> id=3.
//  3. RR_EN=1, all four pending, ack each request immediately -> id sequence 0,1,2,3.
//     Re-trigger all four -> sequence continues 0,1,2,3.
//  4. enable=4'h0, src[0] rises -> pend_o=1 and valid stays 0.
//     Write enable=4'h1 -> valid=1, id=0 two cycles after the write.
//  5. In REQ with id=2, src[2] rises again on the ack cycle -> pend[2] stays 1.
//     After GAP, id=2 is requested again.
//  6. PEND_CLR data=4'h8 while pend=4'hA in IDLE -> pend_o=4'h2.
//     Assert rst while valid=1 -> valid=0, pend_o=0, enable_o=0 the next cycle.

Source files
------------

// File: rtl/clint_irq_arbiter.sv
// Captures rising edges on the CLINT source lines, masks them with the enable register and
// presents one winner to the core as a valid/id request that is held until acknowledged.
module clint_irq_arbiter #(
   parameter int          N_SRC     = 4,
   parameter int          ID_W      = 2,
   parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
   parameter bit          RR_EN     = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] src_irq_i,
   input  logic             wr_en_i,
   input  logic [31:0]      addr_i,
   input  logic [31:0]      data_i,
   output logic             irq_valid_o,
   output logic [ID_W-1:0]  irq_id_o,
   input  logic             irq_ack_i,
   output logic [N_SRC-1:0] pend_o,
   output logic [N_SRC-1:0] enable_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_SRC - 1);

   state_t           state_q, state_d;
   logic [N_SRC-1:0] src_prev_q, src_prev_d;
   logic [N_SRC-1:0] pend_q, pend_d;
   logic [N_SRC-1:0] enable_q, enable_d;
   logic [ID_W-1:0]  rr_last_q, rr_last_d;
   logic             irq_valid_q, irq_valid_d;
   logic [ID_W-1:0]  irq_id_q, irq_id_d;

   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] elig;
   logic [N_SRC-1:0] hi_mask;
   logic [N_SRC-1:0] elig_hi;
   logic [N_SRC-1:0] bus_clr;
   logic [N_SRC-1:0] ack_clr;
   logic [ID_W-1:0]  rr_start;
   logic [ID_W-1:0]  fixed_win;
   logic [ID_W-1:0]  rr_win;
   logic [ID_W-1:0]  winner;
   logic             en_wr;
   logic             clr_wr;
   logic             ack_accept;

   // Data bits above the source count have no register behind them.
   logic unused_data;
   assign unused_data = ^data_i[31:N_SRC];

   function automatic logic [ID_W-1:0] lowest_set(input logic [N_SRC-1:0] v);
      logic [ID_W-1:0] idx;
      idx = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (v[i]) idx = ID_W'(i);
      end
      return idx;
   endfunction

   always_comb begin
      rise   = src_irq_i & ~src_prev_q;
      en_wr  = wr_en_i && (addr_i == BASE_ADDR);
      clr_wr = wr_en_i && (addr_i == BASE_ADDR + 32'd4);
      elig   = pend_q & enable_q;
   end

   // Round-robin: prefer eligible sources at or above rr_last+1, otherwise wrap to the lowest.
   always_comb begin
      rr_start = (rr_last_q == LAST_IDX) ? '0 : rr_last_q + 1'b1;
      hi_mask  = '0;
      for (int i = 0; i < N_SRC; i++) begin
         hi_mask[i] = (i >= int'(rr_start));
      end
      elig_hi   = elig & hi_mask;
      fixed_win = lowest_set(elig);
      rr_win    = (|elig_hi) ? lowest_set(elig_hi) : fixed_win;
      winner    = RR_EN ? rr_win : fixed_win;
   end

   always_comb begin
      state_d     = state_q;
      irq_valid_d = irq_valid_q;
      irq_id_d    = irq_id_q;
      rr_last_d   = rr_last_q;
      ack_accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (|elig) begin
               irq_id_d    = winner;
               irq_valid_d = 1'b1;
               state_d     = REQ;
            end
         end
         REQ: begin
            if (irq_ack_i) begin
               ack_accept  = 1'b1;
               irq_valid_d = 1'b0;
               rr_last_d   = irq_id_q;
               state_d     = GAP;
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            irq_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // A new edge in the same cycle as a clear keeps the pending bit set.
   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < N_SRC; i++) begin
         ack_clr[i] = ack_accept && (irq_id_q == ID_W'(i));
      end
      bus_clr    = clr_wr ? data_i[N_SRC-1:0] : '0;
      pend_d     = (pend_q & ~(ack_clr | bus_clr)) | rise;
      enable_d   = en_wr ? data_i[N_SRC-1:0] : enable_q;
      src_prev_d = src_irq_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         src_prev_q  <= '0;
         pend_q      <= '0;
         enable_q    <= '0;
         rr_last_q   <= '0;
         irq_valid_q <= 1'b0;
         irq_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         src_prev_q  <= src_prev_d;
         pend_q      <= pend_d;
         enable_q    <= enable_d;
         rr_last_q   <= rr_last_d;
         irq_valid_q <= irq_valid_d;
         irq_id_q    <= irq_id_d;
      end
   end

   assign irq_valid_o = irq_valid_q;
   assign irq_id_o    = irq_id_q;
   assign pend_o      = pend_q;
   assign enable_o    = enable_q;

endmodule

// File: tb/tb_clint_irq_arbiter.sv
// Bench for clint_irq_arbiter: fixed-priority and round-robin instances share stimulus and are
// checked every cycle against a behavioural model through an expectation queue.
module tb_clint_irq_arbiter;

   localparam int          N    = 4;
   localparam logic [31:0] BASE = 32'h0000_2000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  src = 4'h0;
   logic        wr_en = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] data = 32'h0;
   logic        ack = 1'b0;

   logic        fix_valid, rr_valid;
   logic [1:0]  fix_id, rr_id;
   logic [3:0]  fix_pend, rr_pend, fix_en, rr_en;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   clint_irq_arbiter #(.N_SRC(4), .ID_W(2), .BASE_ADDR(BASE), .RR_EN(1'b0)) u_fix (
      .clk(clk), .rst(rst), .src_irq_i(src), .wr_en_i(wr_en), .addr_i(addr), .data_i(data),
      .irq_valid_o(fix_valid), .irq_id_o(fix_id), .irq_ack_i(ack),
      .pend_o(fix_pend), .enable_o(fix_en));

   clint_irq_arbiter #(.N_SRC(4), .ID_W(2), .BASE_ADDR(BASE), .RR_EN(1'b1)) u_rr (
      .clk(clk), .rst(rst), .src_irq_i(src), .wr_en_i(wr_en), .addr_i(addr), .data_i(data),
      .irq_valid_o(rr_valid), .irq_id_o(rr_id), .irq_ack_i(ack),
      .pend_o(rr_pend), .enable_o(rr_en));

   typedef struct packed {
      logic [3:0] pf, ef, pr, er;
      logic       vf, vr;
      logic [1:0] idf, idr;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;

   // Model state: index 0 is the fixed-priority instance, 1 the round-robin one.
   logic [3:0] m_pend[2];
   logic [3:0] m_en[2];
   logic [3:0] m_prev;
   bit         m_req[2];
   bit         m_gap[2];
   int         m_id[2];
   int         m_last[2];

   task automatic chk(input string nm, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
      end
   endtask

   task automatic model_step();
      logic [3:0] elig;
      int         w;
      bit         clr;
      if (rst) begin
         for (int m = 0; m < 2; m++) begin
            m_pend[m] = '0; m_en[m] = '0; m_req[m] = 0; m_gap[m] = 0;
            m_id[m] = 0; m_last[m] = 0;
         end
         m_prev = '0;
      end else begin
         for (int m = 0; m < 2; m++) begin
            elig = m_pend[m] & m_en[m];
            for (int i = 0; i < N; i++) begin
               clr = (wr_en && addr == BASE + 32'd4 && data[i]) ||
                     (m_req[m] && ack && m_id[m] == i);
               if (src[i] && !m_prev[i]) m_pend[m][i] = 1'b1;
               else if (clr)             m_pend[m][i] = 1'b0;
            end
            if (wr_en && addr == BASE) m_en[m] = data[3:0];
            if (m_req[m]) begin
               if (ack) begin
                  m_req[m] = 0; m_gap[m] = 1; m_last[m] = m_id[m];
               end
            end else if (m_gap[m]) begin
               m_gap[m] = 0;
            end else if (elig != 0) begin
               w = -1;
               if (m == 0) begin
                  for (int i = 0; i < N; i++) if (elig[i] && w < 0) w = i;
               end else begin
                  for (int k = 1; k <= N; k++) if (elig[(m_last[m] + k) % N] && w < 0) w = (m_last[m] + k) % N;
               end
               m_req[m] = 1; m_id[m] = w;
            end
         end
         m_prev = src;
      end
   endtask

   task automatic tick();
      exp_t x;
      @(posedge clk);
      model_step();
      x.pf = m_pend[0]; x.ef = m_en[0]; x.vf = m_req[0]; x.idf = 2'(m_id[0]);
      x.pr = m_pend[1]; x.er = m_en[1]; x.vr = m_req[1]; x.idr = 2'(m_id[1]);
      exp_q.push_back(x);
      #1;
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      wr_en = 1'b1; addr = a; data = d;
      tick();
      wr_en = 1'b0; addr = 32'h0; data = 32'h0;
   endtask

   task automatic ack_and_settle();
      ack = 1'b1; tick();
      ack = 1'b0; tick(); tick();
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("sb_fix_pend", int'(fix_pend), int'(e.pf));
         chk("sb_fix_en", int'(fix_en), int'(e.ef));
         chk("sb_fix_valid", int'(fix_valid), int'(e.vf));
         if (e.vf) chk("sb_fix_id", int'(fix_id), int'(e.idf));
         chk("sb_rr_pend", int'(rr_pend), int'(e.pr));
         chk("sb_rr_en", int'(rr_en), int'(e.er));
         chk("sb_rr_valid", int'(rr_valid), int'(e.vr));
         if (e.vr) chk("sb_rr_id", int'(rr_id), int'(e.idr));
      end
   end

   initial begin
      logic [31:0] addr_tab[4];
      addr_tab[0] = BASE; addr_tab[1] = BASE + 32'd4; addr_tab[2] = BASE + 32'd8; addr_tab[3] = 32'h0;

      tick(); tick();
      chk("rst_valid", int'(fix_valid), 0);
      chk("rst_id", int'(fix_id), 0);
      chk("rst_pend", int'(fix_pend), 0);
      chk("rst_en", int'(fix_en), 0);
      rst = 1'b0;
      tick();

      // Single source: pending one cycle after the edge, request the cycle after.
      bus_wr(BASE, 32'hF);
      src = 4'h4; tick();
      chk("t1_pend", int'(fix_pend), 4);
      src = 4'h0; tick();
      chk("t1_valid", int'(fix_valid), 1);
      chk("t1_id", int'(fix_id), 2);
      ack = 1'b1; tick();
      chk("t1_ack_pend", int'(fix_pend), 0);
      chk("t1_gap_valid", int'(fix_valid), 0);
      ack = 1'b0; tick(); tick();

      // Two simultaneous edges.
      src = 4'hA; tick();
      src = 4'h0; tick();
      chk("t2_fix_first", int'(fix_id), 1);
      chk("t2_rr_first", int'(rr_id), 3);
      ack = 1'b1; tick();
      ack = 1'b0; tick(); tick();
      chk("t2_fix_valid2", int'(fix_valid), 1);
      chk("t2_fix_second", int'(fix_id), 3);
      chk("t2_rr_second", int'(rr_id), 1);
      ack_and_settle();

      // Leave rr_last at 3 so the round-robin search begins at source 0.
      src = 4'h8; tick();
      src = 4'h0; tick();
      chk("t3_pre_id", int'(rr_id), 3);
      ack_and_settle();
      for (int rep = 0; rep < 2; rep++) begin
         src = 4'hF; tick();
         src = 4'h0; tick();
         for (int k = 0; k < 4; k++) begin
            chk("t3_rr_valid", int'(rr_valid), 1);
            chk("t3_rr_seq", int'(rr_id), k);
            chk("t3_fix_seq", int'(fix_id), k);
            ack_and_settle();
         end
      end

      // Masked source stays pending until enabled.
      bus_wr(BASE, 32'h0);
      src = 4'h1; tick();
      src = 4'h0; tick();
      chk("t4_pend", int'(fix_pend), 1);
      chk("t4_masked", int'(fix_valid), 0);
      bus_wr(BASE, 32'h1);
      chk("t4_w1_valid", int'(fix_valid), 0);
      tick();
      chk("t4_w2_valid", int'(fix_valid), 1);
      chk("t4_w2_id", int'(fix_id), 0);
      ack_and_settle();

      // New edge on the ack cycle survives the clear.
      bus_wr(BASE, 32'hF);
      src = 4'h4; tick();
      src = 4'h0; tick();
      chk("t5_id", int'(fix_id), 2);
      ack = 1'b1; src = 4'h4; tick();
      chk("t5_pend_kept", int'(fix_pend), 4);
      chk("t5_gap", int'(fix_valid), 0);
      ack = 1'b0; src = 4'h0; tick(); tick();
      chk("t5_again_valid", int'(fix_valid), 1);
      chk("t5_again_id", int'(fix_id), 2);
      ack_and_settle();

      // Write-1-to-clear, clear under a live request, then reset mid-request.
      bus_wr(BASE, 32'h0);
      src = 4'hA; tick();
      src = 4'h0; tick();
      chk("t6_pend", int'(fix_pend), 10);
      bus_wr(BASE + 32'd4, 32'h8);
      chk("t6_clr", int'(fix_pend), 2);
      bus_wr(BASE, 32'hF);
      tick();
      chk("t6_valid", int'(fix_valid), 1);
      chk("t6_id", int'(fix_id), 1);
      bus_wr(BASE + 32'd4, 32'h2);
      chk("t6_clr_req_pend", int'(fix_pend), 0);
      chk("t6_req_held", int'(fix_valid), 1);
      rst = 1'b1; tick();
      chk("t6_rst_valid", int'(fix_valid), 0);
      chk("t6_rst_pend", int'(fix_pend), 0);
      chk("t6_rst_en", int'(fix_en), 0);
      chk("t6_rst_rr_valid", int'(rr_valid), 0);
      rst = 1'b0; tick();

      for (int c = 0; c < 3000; c++) begin
         src   = src ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
         wr_en = ($urandom_range(0, 7) == 0);
         addr  = addr_tab[$urandom_range(0, 3)];
         data  = $urandom;
         ack   = 1'($urandom_range(0, 1));
         rst   = ($urandom_range(0, 399) == 0);
         tick();
      end
      rst = 1'b0; wr_en = 1'b0; ack = 1'b0; src = 4'h0;
      tick();
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
